// File: rtl/cordic_pkg.sv
// cordic_pkg: elaboration-time constants and width helpers for the vectoring CORDIC
package cordic_pkg;
  localparam logic [127:0] TWO_PI_Q64 = 128'h6_487E_D511_0B46_11A6;
  function automatic int cordic_w(input int data_w, input int guard);
    return data_w + guard + 2;
  endfunction
  // atan(2^-k) by its odd power series in Q64, then rescaled to turns of 2^width
  function automatic logic [63:0] atan_lut(input int k, input int width);
    logic [127:0] acc, term;
    if (k == 0) return 64'(1) << (width - 3);
    acc = '0;
    for (int n = 0; k * (2 * n + 1) < 64; n++) begin
      term = (128'(1) << (64 - k * (2 * n + 1))) / 128'(2 * n + 1);
      acc = n[0] ? acc - term : acc + term;
    end
    acc = ((acc << width) + (TWO_PI_Q64 >> 1)) / TWO_PI_Q64;
    return acc[63:0];
  endfunction
  // K^2 accumulated in Q60, then round(2^17/K) via integer sqrt with 8 extra bits
  function automatic int cordic_kinv(input int stages);
    logic [127:0] p, v, r, t;
    p = 128'(1) << 60;
    for (int k = 0; k < stages; k++) p = p + (p >> (2 * k));
    v = (128'(1) << 110) / p;
    r = '0;
    for (int b = 40; b >= 0; b--) begin
      t = r | (128'(1) << b);
      if (t * t <= v) r = t;
    end
    return int'((r + 128) >> 8);
  endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one registered vectoring micro-rotation with its valid bit
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int K = 0,
  parameter int W = 26,
  parameter int ZW = 24,
  parameter int PHASE_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                src_v,
  input  logic signed [W-1:0] src_i,
  input  logic signed [W-1:0] src_q,
  input  logic [ZW-1:0]       src_z,
  output logic                dst_v,
  output logic signed [W-1:0] dst_i,
  output logic signed [W-1:0] dst_q,
  output logic [ZW-1:0]       dst_z
);
  localparam logic [ZW-1:0] ATAN = ZW'(atan_lut(K, ZW));
  logic neg;
  assign neg = src_q[W-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dst_v <= 1'b0;
      dst_i <= '0;
      dst_q <= '0;
      dst_z <= '0;
    end else begin
      dst_v <= src_v;
      dst_i <= neg ? src_i - (src_q >>> K) : src_i + (src_q >>> K);
      dst_q <= neg ? src_q + (src_i >>> K) : src_q - (src_i >>> K);
      dst_z <= (PHASE_EN != 0) ? (neg ? src_z - ATAN : src_z + ATAN) : '0;
    end
endmodule

// File: rtl/cordic_vec_pipe.sv
// cordic_vec_pipe: pipelined vectoring CORDIC returning magnitude and phase
module cordic_vec_pipe
  import cordic_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int STAGES = 12,
  parameter int GUARD = 4,
  parameter int PHASE_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_mag,
  output logic signed [DATA_W-1:0] out_phase
);
  localparam int W = cordic_w(DATA_W, GUARD);
  localparam int ZW = DATA_W + GUARD;
  localparam int PW = W + 19;
  localparam int SH = GUARD + 17;
  localparam logic [17:0] KINV = 18'(cordic_kinv(STAGES));
  logic                cv [STAGES+1];
  logic signed [W-1:0] ci [STAGES+1];
  logic signed [W-1:0] cq [STAGES+1];
  logic [ZW-1:0]       cz [STAGES+1];
  logic                fv, pv;
  logic signed [W-1:0] fi, fq, ie, qe;
  logic [ZW-1:0]       fz, pz;
  logic signed [PW-1:0] prod, mr;
  logic [DATA_W-1:0]   mag_n;
  assign ie = {{2{in_i[DATA_W-1]}}, in_i, {GUARD{1'b0}}};
  assign qe = {{2{in_q[DATA_W-1]}}, in_q, {GUARD{1'b0}}};
  // left half-plane is folded by 180 degrees; +pi and -pi share one code
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fv <= 1'b0;
      fi <= '0;
      fq <= '0;
      fz <= '0;
    end else begin
      fv <= in_valid;
      fi <= in_i[DATA_W-1] ? -ie : ie;
      fq <= in_i[DATA_W-1] ? -qe : qe;
      fz <= (PHASE_EN != 0 && in_i[DATA_W-1]) ? {1'b1, {(ZW-1){1'b0}}} : '0;
    end
  assign cv[0] = fv;
  assign ci[0] = fi;
  assign cq[0] = fq;
  assign cz[0] = fz;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cordic_vec_stage #(.K(k), .W(W), .ZW(ZW), .PHASE_EN(PHASE_EN)) u_stage (
      .clk(clk), .reset(reset),
      .src_v(cv[k]), .src_i(ci[k]), .src_q(cq[k]), .src_z(cz[k]),
      .dst_v(cv[k+1]), .dst_i(ci[k+1]), .dst_q(cq[k+1]), .dst_z(cz[k+1])
    );
  end
  assign mr = (prod + (PW'(1) << (SH - 1))) >>> SH;
  assign mag_n = mr[PW-1] ? '0 : (|mr[PW-2:DATA_W]) ? '1 : mr[DATA_W-1:0];
  // a zero vector keeps i at zero through every stage; force its phase to 0
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pv <= 1'b0;
      prod <= '0;
      pz <= '0;
      out_valid <= 1'b0;
      out_mag <= '0;
      out_phase <= '0;
    end else begin
      pv <= cv[STAGES];
      prod <= PW'(ci[STAGES]) * PW'($signed({1'b0, KINV}));
      pz <= (ci[STAGES] == '0) ? '0 : cz[STAGES];
      out_valid <= pv;
      out_mag <= mag_n;
      out_phase <= DATA_W'((pz + (ZW'(1) << (GUARD - 1))) >> GUARD);
    end
endmodule

// File: tb/tb_cordic_vec_pipe.sv
// tb_cordic_vec_pipe: directed and random stream checks of latency, magnitude and phase
module tb_cordic_vec_pipe;
  typedef struct {int due; int mag; int ph; int mtol; int ptol;} exp_t;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_valid;
  logic signed [19:0] in_i = '0, in_q = '0, out_phase;
  logic [19:0] out_mag;
  int checks = 0, errors = 0, ncount = 0;
  int exp_mag = 0, exp_ph = 0, exp_mtol = 0, exp_ptol = 0;
  exp_t sb[$];
  cordic_vec_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_mag(out_mag), .out_phase(out_phase)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
    longint d;
    d = got - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at t=%0t", tag, got, exp, tol, $time);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    logic due;
    logic signed [19:0] dw;
    ncount++;
    if (reset) begin
      sb.delete();
      check("rst_valid", longint'(out_valid), 0);
      check("rst_mag", longint'(out_mag), 0);
      check("rst_phase", longint'(out_phase), 0);
    end else begin
      due = sb.size() > 0 && sb[0].due == ncount;
      check("valid", longint'(out_valid), longint'(due));
      if (due) begin
        e = sb.pop_front();
        if (out_valid) begin
          dw = 20'(int'(out_phase) - e.ph);
          check("mag", longint'(out_mag), e.mag, e.mtol);
          check("phase", longint'(e.ph) + longint'(dw), e.ph, e.ptol);
        end
      end
      if (in_valid) sb.push_back('{ncount + 15, exp_mag, exp_ph, exp_mtol, exp_ptol});
    end
  end
  task automatic drive(input logic v, input int i, input int q, input int m, input int p, input int mt = 2, input int pt = 96);
    in_valid = v;
    in_i = 20'(i);
    in_q = 20'(q);
    exp_mag = m;
    exp_ph = p;
    exp_mtol = mt;
    exp_ptol = pt;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 0);
  endtask
  task automatic drive_rand();
    logic signed [19:0] ri, rq;
    real ang;
    ri = 20'($urandom);
    rq = 20'($urandom);
    ang = $atan2(real'(rq), real'(ri)) / (2.0 * 3.14159265358979) * 1048576.0;
    drive(1'b1, int'(ri), int'(rq), int'($sqrt(real'(ri) * real'(ri) + real'(rq) * real'(rq))), int'(ang));
  endtask
  initial begin
    int sent;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    drive(1'b1, 1000, 0, 1000, 0);
    idle(20);
    drive(1'b1, 0, 1000, 1000, 262144);
    idle(20);
    drive(1'b1, -524288, -524288, 741455, -393216);
    idle(20);
    drive(1'b1, -524288, 0, 524288, -524288);
    idle(20);
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 1000, 1000, 1414, 131072);
    drive(1'b1, 1000, -1000, 1414, -131072);
    idle(20);
    sent = 0;
    while (sent < 200) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 6));
      else begin
        drive_rand();
        sent++;
      end
    end
    idle(20);
    repeat (10) drive_rand();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(25);
    drive(1'b1, 0, -1000, 1000, -262144);
    idle(20);
    check("drain", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
